// File: rtl/rect_plotter_if.sv
// Command handshake and pixel-stream signals between a command source and the rectangle plotter.
interface rect_plotter_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SIZE_W   = 4
) ();
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [X_W-1:0]      cmd_x;
  logic [Y_W-1:0]      cmd_y;
  logic [SIZE_W-1:0]   cmd_w;
  logic [SIZE_W-1:0]   cmd_h;
  logic [COLOUR_W-1:0] cmd_colour;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                done;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
    input  cmd_ready, x, y, colour, plot, done
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
    output cmd_ready, x, y, colour, plot, done
  );
endinterface

// File: rtl/rect_plotter.sv
// Command-driven pixel generator: clipped filled rectangles and full-screen fills,
// one registered pixel per clock on the plot interface.
module rect_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SIZE_W   = 4
) (
  input logic           clk,
  input logic           reset,
  rect_plotter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECT = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [X_W:0]   SW     = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   SH     = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

  logic [1:0]          state;
  logic [X_W-1:0]      lx;
  logic [Y_W-1:0]      ly;
  logic [SIZE_W-1:0]   lw, lh, dx, dy;
  logic [COLOUR_W-1:0] lcol;

  logic                last_dx;
  logic [SIZE_W-1:0]   ndx, ndy, ox, oy;
  logic [X_W-1:0]      bx;
  logic [Y_W-1:0]      by;
  logic [X_W:0]        sx;
  logic [Y_W:0]        sy;
  logic                pin;

  // In IDLE the first pixel comes straight from the command inputs so that it
  // is on the outputs in the cycle right after acceptance.
  always_comb begin
    last_dx = (dx == lw);
    ndx     = last_dx ? '0 : dx + 1'b1;
    ndy     = last_dx ? dy + 1'b1 : dy;
    if (state == S_IDLE) begin
      bx = bus.cmd_x;
      by = bus.cmd_y;
      ox = '0;
      oy = '0;
    end else begin
      bx = lx;
      by = ly;
      ox = ndx;
      oy = ndy;
    end
    sx  = {1'b0, bx} + (X_W+1)'(ox);
    sy  = {1'b0, by} + (Y_W+1)'(oy);
    pin = (sx < SW) && (sy < SH);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      lx            <= '0;
      ly            <= '0;
      lw            <= '0;
      lh            <= '0;
      lcol          <= '0;
      dx            <= '0;
      dy            <= '0;
      bus.x         <= '0;
      bus.y         <= '0;
      bus.colour    <= '0;
      bus.plot      <= 1'b0;
      bus.done      <= 1'b0;
      bus.cmd_ready <= 1'b1;
    end else begin
      bus.plot <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            lx            <= bus.cmd_x;
            ly            <= bus.cmd_y;
            lw            <= bus.cmd_w;
            lh            <= bus.cmd_h;
            lcol          <= bus.cmd_colour;
            dx            <= '0;
            dy            <= '0;
            bus.cmd_ready <= 1'b0;
            case (bus.cmd_op)
              2'b00: begin
                state      <= S_RECT;
                bus.x      <= sx[X_W-1:0];
                bus.y      <= sy[Y_W-1:0];
                bus.colour <= bus.cmd_colour;
                bus.plot   <= pin;
              end
              2'b01: begin
                state      <= S_FILL;
                bus.x      <= '0;
                bus.y      <= '0;
                bus.colour <= bus.cmd_colour;
                bus.plot   <= 1'b1;
              end
              default: begin
                state    <= S_DONE;
                bus.done <= 1'b1;
              end
            endcase
          end
        end
        S_RECT: begin
          if (last_dx && (dy == lh)) begin
            state    <= S_DONE;
            bus.done <= 1'b1;
          end else begin
            dx         <= ndx;
            dy         <= ndy;
            bus.x      <= sx[X_W-1:0];
            bus.y      <= sy[Y_W-1:0];
            bus.colour <= lcol;
            bus.plot   <= pin;
          end
        end
        S_FILL: begin
          // The output registers double as the fill scan counters.
          if ((bus.x == X_LAST) && (bus.y == Y_LAST)) begin
            state    <= S_DONE;
            bus.done <= 1'b1;
          end else if (bus.x == X_LAST) begin
            bus.x    <= '0;
            bus.y    <= bus.y + 1'b1;
            bus.plot <= 1'b1;
          end else begin
            bus.x    <= bus.x + 1'b1;
            bus.plot <= 1'b1;
          end
        end
        default: begin
          state         <= S_IDLE;
          bus.cmd_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rect_plotter.sv
// Directed bench for rect_plotter: rectangles, clipping, fill, reset abort, back-to-back and reserved ops.
module tb_rect_plotter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rect_plotter_if #(.X_W(8), .Y_W(7), .COLOUR_W(3), .SIZE_W(4)) bus ();

  rect_plotter #(
    .X_W(8), .Y_W(7), .COLOUR_W(3), .SCREEN_W(160), .SCREEN_H(120), .SIZE_W(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic accept(input int op, input int cx, input int cy, input int w, input int h, input int c);
    bus.cmd_op     = 2'(op);
    bus.cmd_x      = 8'(cx);
    bus.cmd_y      = 7'(cy);
    bus.cmd_w      = 4'(w);
    bus.cmd_h      = 4'(h);
    bus.cmd_colour = 3'(c);
    bus.cmd_valid  = 1'b1;
    tick();
    bus.cmd_valid  = 1'b0;
  endtask

  // Issues a rectangle and checks every pixel cycle, then done and ready timing.
  task automatic run_rect(input int cx, input int cy, input int w, input int h, input int c,
                          input int exp_plots, input int last_x, input int last_y);
    int plots = 0;
    accept(0, cx, cy, w, h, c);
    for (int j = 0; j <= h; j++) begin
      for (int i = 0; i <= w; i++) begin
        int ex = cx + i;
        int ey = cy + j;
        if (i != 0 || j != 0) tick();
        chk("rect_x", bus.x, ex % 256);
        chk("rect_y", bus.y, ey % 128);
        chk("rect_plot", bus.plot, (ex < 160 && ey < 120) ? 1 : 0);
        chk("rect_colour", bus.colour, c);
        chk("rect_busy", bus.cmd_ready, 0);
        if (bus.plot) plots++;
      end
    end
    chk("rect_last_x", bus.x, last_x);
    chk("rect_last_y", bus.y, last_y);
    chk("rect_plot_count", plots, exp_plots);
    tick();
    chk("rect_done", bus.done, 1);
    chk("rect_done_plot", bus.plot, 0);
    chk("rect_done_ready", bus.cmd_ready, 0);
    tick();
    chk("rect_ready", bus.cmd_ready, 1);
    chk("rect_done_clear", bus.done, 0);
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'd0;
    bus.cmd_x      = 8'd0;
    bus.cmd_y      = 7'd0;
    bus.cmd_w      = 4'd0;
    bus.cmd_h      = 4'd0;
    bus.cmd_colour = 3'd0;

    // Reset, with cmd_valid asserted to confirm it is not accepted
    reset = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd1;
    tick();
    tick();
    chk("rst_x", bus.x, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_colour", bus.colour, 0);
    chk("rst_plot", bus.plot, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("idle_ready", bus.cmd_ready, 1);
    chk("idle_plot", bus.plot, 0);

    // Basic 2x3 rectangle
    run_rect(10, 20, 1, 2, 5, 6, 11, 22);

    // Clipping at the bottom-right corner
    run_rect(158, 118, 3, 3, 3, 4, 161, 121);

    // Full-screen fill
    begin
      int bad = 0;
      int plots = 0;
      accept(1, 77, 33, 9, 9, 0);
      chk("fill_first_x", bus.x, 0);
      chk("fill_first_y", bus.y, 0);
      for (int j = 0; j < 120; j++) begin
        for (int i = 0; i < 160; i++) begin
          if (i != 0 || j != 0) tick();
          if (bus.x !== 8'(i) || bus.y !== 7'(j) || bus.plot !== 1'b1 ||
              bus.colour !== 3'd0 || bus.done !== 1'b0) bad++;
          if (bus.plot) plots++;
        end
      end
      chk("fill_seq_errors", bad, 0);
      chk("fill_plot_count", plots, 19200);
      chk("fill_last_x", bus.x, 159);
      chk("fill_last_y", bus.y, 119);
      tick();
      chk("fill_done", bus.done, 1);
      chk("fill_done_plot", bus.plot, 0);
      tick();
      chk("fill_ready", bus.cmd_ready, 1);
      chk("fill_idle_plot", bus.plot, 0);
    end

    // Reset in the middle of a fill
    accept(1, 0, 0, 0, 0, 6);
    for (int k = 1; k < 50; k++) tick();
    chk("abort_busy", bus.cmd_ready, 0);
    chk("abort_plotting", bus.plot, 1);
    reset = 1'b0;
    tick();
    chk("abort_x", bus.x, 0);
    chk("abort_y", bus.y, 0);
    chk("abort_colour", bus.colour, 0);
    chk("abort_plot", bus.plot, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_ready", bus.cmd_ready, 1);
    reset = 1'b1;
    tick();
    chk("abort_no_done", bus.done, 0);
    chk("abort_no_plot", bus.plot, 0);
    run_rect(0, 0, 0, 0, 4, 1, 0, 0);

    // Back-to-back: held valid, single-pixel rect then a reserved op
    bus.cmd_op     = 2'd0;
    bus.cmd_x      = 8'd3;
    bus.cmd_y      = 7'd4;
    bus.cmd_w      = 4'd0;
    bus.cmd_h      = 4'd0;
    bus.cmd_colour = 3'd2;
    bus.cmd_valid  = 1'b1;
    tick();
    chk("b2b_px_x", bus.x, 3);
    chk("b2b_px_y", bus.y, 4);
    chk("b2b_px_plot", bus.plot, 1);
    chk("b2b_px_colour", bus.colour, 2);
    bus.cmd_op     = 2'd3;
    bus.cmd_x      = 8'd99;
    bus.cmd_y      = 7'd55;
    bus.cmd_w      = 4'd5;
    bus.cmd_colour = 3'd7;
    tick();
    chk("b2b_done1", bus.done, 1);
    chk("b2b_done1_plot", bus.plot, 0);
    chk("b2b_done1_ready", bus.cmd_ready, 0);
    tick();
    chk("b2b_idle_ready", bus.cmd_ready, 1);
    chk("b2b_idle_done", bus.done, 0);
    chk("b2b_idle_plot", bus.plot, 0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("rsv_done", bus.done, 1);
    chk("rsv_plot", bus.plot, 0);
    chk("rsv_hold_x", bus.x, 3);
    chk("rsv_hold_y", bus.y, 4);
    chk("rsv_hold_colour", bus.colour, 2);
    tick();
    chk("rsv_ready", bus.cmd_ready, 1);
    chk("rsv_done_clear", bus.done, 0);
    chk("rsv_no_plot", bus.plot, 0);

    // Maximum size rectangle
    run_rect(0, 0, 15, 15, 7, 256, 15, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rect_plotter.md
# rect_plotter

Parametrised pixel-stream generator for the VGA framebuffer path. It accepts one drawing command per valid/ready handshake and emits one pixel per clock as x/y/colour/plot, directly compatible with the adapter's plot interface. Supported commands are a filled rectangle of programmable width and height, clipped at the screen edge, and a full-screen fill in any colour. It replaces the fixed 4x4 square and black-only clear path with a single command-driven engine.

## Interface
Parameters:
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COLOUR_W, 3, colour width
- SCREEN_W, 160, visible columns; must satisfy SCREEN_W ≤ 2^X_W
- SCREEN_H, 120, visible rows; must satisfy SCREEN_H ≤ 2^Y_W
- SIZE_W, 4, width of the size fields; rectangle side = field + 1, range 1..2^SIZE_W

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle and able to accept a command
- cmd_op  in  2  00 rectangle, 01 screen fill, 10/11 reserved
- cmd_x  in  X_W  rectangle origin column (top-left)
- cmd_y  in  Y_W  rectangle origin row (top-left)
- cmd_w  in  SIZE_W  rectangle width minus 1
- cmd_h  in  SIZE_W  rectangle height minus 1
- cmd_colour  in  COLOUR_W  pixel colour
- x  out  X_W  pixel column
- y  out  Y_W  pixel row
- colour  out  COLOUR_W  pixel colour
- plot  out  1  write enable for the current pixel
- done  out  1  one-cycle pulse when a command completes

## Operation
- States:
  - IDLE, with cmd_ready=1.
  - RECT.
  - FILL.
  - DONE, which pulses done=1 for one cycle.
- All outputs are registered. cmd_ready is 1 only in IDLE.
- Accept: cmd_valid & cmd_ready at a rising edge latches all cmd_* fields. The block then goes to RECT (op 00), FILL (op 01) or DONE (op 10/11).
- Reserved ops emit no pixel and produce only the done pulse.
- RECT:
  - Scans row-major with offsets dx = 0..cmd_w (inner) and dy = 0..cmd_h (outer).
  - Emits x = cmd_x+dx and y = cmd_y+dy each cycle, with colour = latched colour.
  - Sums are computed at X_W+1 and Y_W+1 bits.
  - plot=1 only when x < SCREEN_W and y < SCREEN_H. Clipped pixels still take their cycle with plot=0; they are never clamped or wrapped.
  - Output x/y carry the low X_W/Y_W bits of the sums.
  - After the pixel with dx=cmd_w and dy=cmd_h, the block goes to DONE.
- FILL:
  - Scans x = 0..SCREEN_W-1 (inner) and y = 0..SCREEN_H-1 (outer), with plot=1 on every pixel.
  - After pixel (SCREEN_W-1, SCREEN_H-1), the block goes to DONE.
- DONE: plot=0, done=1, then IDLE.
- Outside RECT/FILL, plot=0. x/y/colour hold their last values.
- cmd_* inputs are ignored while cmd_ready=0. Command fields may change freely after acceptance.

## Timing
- Reset (reset=0 at a rising edge) acts from any state, including mid-command, and the in-progress command is discarded:
  - state becomes IDLE;
  - x=0, y=0, colour=0, plot=0, done=0, cmd_ready=1;
  - internal counters are cleared.
- A cmd_valid sampled on the same edge as reset=0 is not accepted.
- Accept at edge T:
  - pixel k (0-based) is on the outputs during cycle T+1+k;
  - N = (cmd_w+1)(cmd_h+1) for RECT, or SCREEN_W*SCREEN_H for FILL, or 0 for reserved ops;
  - done is high during cycle T+1+N;
  - cmd_ready returns high during cycle T+2+N.
- Back-to-back commands: the earliest next accept is edge T+2+N. A continuously held cmd_valid therefore gives exactly one idle cycle (cmd_ready=1) between commands.
- Throughput: exactly one pixel per clock with no bubbles inside a command.

## Test plan
- Rectangle: reset, then accept op=00, x=10, y=20, w=1, h=2, colour=5 → 6 plot cycles in order (10,20) (11,20) (10,21) (11,21) (10,22) (11,22), all colour 5. done is on the 7th cycle after accept; cmd_ready=1 on the 8th.
- Clipping: op=00, x=158, y=118, w=3, h=3 → 16 pixel cycles with plot=1 only for (158,118), (159,118), (158,119), (159,119). The other 12 cycles have plot=0, then done.
- Screen fill: op=01, colour=0 → 19200 consecutive plot cycles, the first (0,0), then (1,0), and the last (159,119). done follows on the next cycle; no other plot cycles occur.
- Reset mid-operation: start op=01, drive reset=0 on cycle 50 → outputs are zero and cmd_ready=1 on the following cycle, with no done pulse. A new op=00, x=0, y=0, w=0, h=0 then produces a single plot at (0,0).
- Back-to-back and reserved ops: hold cmd_valid=1 with op=00, w=0, h=0, then switch to op=11 → one plot, done, one idle cycle, then a done pulse with zero plot cycles. Changing cmd_* while cmd_ready=0 has no effect.
- Maximum size: op=00, x=0, y=0, w=15, h=15, colour=7 → 256 plotted pixels ending at (15,15), then done.
